genesis_pad_emulator: RTL and testbench

GENESIS_PAD_EMULATOR -- requirements
Module: genesis_pad_emulator

---
 rtl/genesis_pad_emulator.sv | 127 ++++++++++++
 tb/tb_genesis_pad_emulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/genesis_pad_emulator.sv
// Emulates a Genesis/Mega Drive 3- or 6-button controller driven by the console's
// TH/SELECT line: the read cycle is tracked by counting SELECT falling edges.
module genesis_pad_emulator #(
    parameter int sync_stages   = 2,
    parameter int timeout_ticks = 75000
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iSELECT,
    input  logic [11:0] iBUTTONS,
    input  logic        iMODE_6BTN,
    output logic [5:0]  oGENPAD,
    output logic [2:0]  oPHASE
);

    localparam int STAGES = (sync_stages < 2) ? 2 : sync_stages;
    localparam int IDLE_W = $clog2(timeout_ticks + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(timeout_ticks);

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_1    = 3'd1,
        PH_2    = 3'd2,
        PH_3    = 3'd3,
        PH_4    = 3'd4
    } phase_t;

    logic [STAGES-1:0] sync_q;
    logic              sel_d_q;
    logic              sel_s;
    logic              sel_fall;
    logic              sel_rise;

    phase_t            k_q, k_d;
    logic              mode_q, mode_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [5:0]        pad_q, pad_d;

    logic btn_z, btn_y, btn_x, btn_m, btn_s, btn_c;
    logic btn_b, btn_a, btn_u, btn_dn, btn_l, btn_r;
    logic [5:0] pad_norm;

    assign {btn_z, btn_y, btn_x, btn_m, btn_s, btn_c,
            btn_b, btn_a, btn_u, btn_dn, btn_l, btn_r} = iBUTTONS;

    // Synchronizer and delay flop idle high so a released reset with SELECT low
    // is seen as the first falling edge of a read cycle.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            sync_q  <= '1;
            sel_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], iSELECT};
            sel_d_q <= sel_s;
        end
    end

    assign sel_s    = sync_q[STAGES-1];
    assign sel_fall = sel_d_q & ~sel_s;
    assign sel_rise = ~sel_d_q & sel_s;

    always_comb begin
        k_d    = k_q;
        mode_d = mode_q;
        idle_d = idle_q;

        if (k_q == PH_IDLE) begin
            mode_d = iMODE_6BTN;
        end

        // An edge always wins over a timeout landing in the same cycle.
        if (sel_fall) begin
            case (k_q)
                PH_IDLE: k_d = PH_1;
                PH_1:    k_d = PH_2;
                PH_2:    k_d = mode_q ? PH_3 : PH_1;
                PH_3:    k_d = PH_4;
                default: k_d = PH_1;
            endcase
        end else if (idle_q == IDLE_MAX) begin
            k_d = PH_IDLE;
        end

        if (sel_fall || sel_rise) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    assign pad_norm = {~btn_c, ~btn_b, ~btn_u, ~btn_dn, ~btn_l, ~btn_r};

    // Output is built from the phase being entered so it lines up with sel_s.
    always_comb begin
        pad_d = sel_s ? pad_norm : {~btn_s, ~btn_a, ~btn_u, ~btn_dn, 2'b00};
        if (mode_q) begin
            case (k_d)
                PH_3: pad_d = sel_s ? {~btn_c, ~btn_b, ~btn_z, ~btn_y, ~btn_x, ~btn_m}
                                    : {~btn_s, ~btn_a, 4'b0000};
                PH_4: begin
                    if (!sel_s) begin
                        pad_d = {~btn_s, ~btn_a, 4'b1111};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            k_q    <= PH_IDLE;
            mode_q <= 1'b0;
            idle_q <= '0;
            pad_q  <= 6'h3F;
        end else begin
            k_q    <= k_d;
            mode_q <= mode_d;
            idle_q <= idle_d;
            pad_q  <= pad_d;
        end
    end

    assign oGENPAD = pad_q;
    assign oPHASE  = k_q;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// Directed bench for genesis_pad_emulator: SELECT transactions push expected pad/phase
// into a scoreboard that is popped once the synchronizer latency has elapsed.
module tb_genesis_pad_emulator;

    localparam int T     = 2000;
    localparam int HALF3 = 1000;
    localparam int HALF  = 12;

    logic        iCLK       = 1'b0;
    logic        iRESET     = 1'b0;
    logic        iSELECT    = 1'b1;
    logic [11:0] iBUTTONS   = 12'h000;
    logic        iMODE_6BTN = 1'b0;
    logic [5:0]  oGENPAD;
    logic [2:0]  oPHASE;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [5:0] pad;
        logic [2:0] phase;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    genesis_pad_emulator #(
        .sync_stages   (2),
        .timeout_ticks (T)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iSELECT    (iSELECT),
        .iBUTTONS   (iBUTTONS),
        .iMODE_6BTN (iMODE_6BTN),
        .oGENPAD    (oGENPAD),
        .oPHASE     (oPHASE)
    );

    always #10 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic drive_sel(input logic v, input logic [5:0] pad, input logic [2:0] ph,
                             input string tag);
        exp_t  e;
        string t;
        iSELECT = v;
        e.pad   = pad;
        e.phase = ph;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        tick(3);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".pad"}, 32'(oGENPAD), 32'(e.pad));
        check({t, ".phase"}, 32'(oPHASE), 32'(e.phase));
        $display("sel=%0b pad=%b phase=%0d exp_pad=%b exp_phase=%0d [%s]",
                 v, oGENPAD, oPHASE, e.pad, e.phase, t);
    endtask

    task automatic pair(input logic [5:0] lo, input logic [5:0] hi, input logic [2:0] ph,
                        input string tag, input int half);
        drive_sel(1'b0, lo, ph, {tag, ".lo"});
        tick(half - 3);
        drive_sel(1'b1, hi, ph, {tag, ".hi"});
        tick(half - 3);
    endtask

    task automatic expire(input string tag);
        tick(T + 5);
        check({tag, ".timeout_phase"}, 32'(oPHASE), 32'd0);
    endtask

    initial begin
        // Reset state
        #1 iRESET = 1'b1;
        #1;
        check("rst.async_pad", 32'(oGENPAD), 32'h3F);
        check("rst.async_phase", 32'(oPHASE), 32'd0);
        tick(2);
        iRESET = 1'b0;
        tick(5);
        check("rst.release_pad", 32'(oGENPAD), 32'h3F);
        check("rst.release_phase", 32'(oPHASE), 32'd0);

        // Latency: pad changes exactly three cycles after SELECT toggles
        iBUTTONS = 12'h011;
        tick(2);
        check("lat.idle_hi", 32'(oGENPAD), 32'b111110);
        iSELECT = 1'b0;
        tick(1);
        check("lat.c1", 32'(oGENPAD), 32'b111110);
        tick(1);
        check("lat.c2", 32'(oGENPAD), 32'b111110);
        tick(1);
        check("lat.c3_pad", 32'(oGENPAD), 32'b101100);
        check("lat.c3_phase", 32'(oPHASE), 32'd1);
        drive_sel(1'b1, 6'b111110, 3'd1, "lat.rise");
        // Button change shows one cycle later within the same level
        iBUTTONS = 12'h000;
        tick(1);
        check("btn.release", 32'(oGENPAD), 32'b111111);
        iBUTTONS = 12'h011;
        tick(1);
        check("btn.press", 32'(oGENPAD), 32'b111110);
        expire("lat");

        // 3-button mode, 8 toggles at 20 us halves
        for (int i = 0; i < 4; i++) begin
            pair(6'b101100, 6'b111110, 3'((i % 2) + 1), $sformatf("btn3.%0d", i), HALF3);
        end
        expire("btn3");

        // Mode switched mid-cycle must not affect the current cycle
        iBUTTONS = 12'h900;
        pair(6'b111100, 6'b111111, 3'd1, "latch.k1", HALF);
        pair(6'b111100, 6'b111111, 3'd2, "latch.k2", HALF);
        iMODE_6BTN = 1'b1;
        pair(6'b111100, 6'b111111, 3'd1, "latch.hold", HALF);
        expire("latch");

        // 6-button full cycle, new mode now latched
        pair(6'b111100, 6'b111111, 3'd1, "btn6.p1", HALF);
        pair(6'b111100, 6'b111111, 3'd2, "btn6.p2", HALF);
        pair(6'b110000, 6'b110110, 3'd3, "btn6.p3", HALF);
        pair(6'b111111, 6'b111111, 3'd4, "btn6.p4", HALF);
        pair(6'b111100, 6'b111111, 3'd1, "btn6.wrap", HALF);
        expire("btn6");

        // Timeout after three falling edges restarts at k=1
        pair(6'b111100, 6'b111111, 3'd1, "tmo.k1", HALF);
        pair(6'b111100, 6'b111111, 3'd2, "tmo.k2", HALF);
        drive_sel(1'b0, 6'b110000, 3'd3, "tmo.k3.lo");
        tick(HALF - 3);
        drive_sel(1'b1, 6'b110110, 3'd3, "tmo.k3.hi");
        tick(T + 10);
        check("tmo.before_phase", 32'(oPHASE), 32'd0);
        check("tmo.before_pad", 32'(oGENPAD), 32'b111111);
        drive_sel(1'b0, 6'b111100, 3'd1, "tmo.after.lo");
        drive_sel(1'b1, 6'b111111, 3'd1, "tmo.after.hi");
        expire("tmo");

        // Falling edge lands in the same cycle the idle counter hits the limit
        pair(6'b111100, 6'b111111, 3'd1, "race.k1", HALF);
        drive_sel(1'b0, 6'b111100, 3'd2, "race.k2.lo");
        tick(HALF - 3);
        drive_sel(1'b1, 6'b111111, 3'd2, "race.k2.hi");
        tick(T - 2);
        iSELECT = 1'b0;
        tick(2);
        check("race.idle_at_limit", 32'(dut.idle_q), 32'(T));
        check("race.phase_before", 32'(oPHASE), 32'd2);
        tick(1);
        check("race.phase_after", 32'(oPHASE), 32'd3);
        check("race.idle_cleared", 32'(dut.idle_q), 32'd0);
        check("race.pad_after", 32'(oGENPAD), 32'b110000);
        iSELECT = 1'b1;
        tick(HALF);
        expire("race");

        // Reset in the middle of a read cycle
        pair(6'b111100, 6'b111111, 3'd1, "rmid.k1", HALF);
        pair(6'b111100, 6'b111111, 3'd2, "rmid.k2", HALF);
        drive_sel(1'b0, 6'b110000, 3'd3, "rmid.k3.lo");
        #3 iRESET = 1'b1;
        #1;
        check("rmid.pad_now", 32'(oGENPAD), 32'h3F);
        check("rmid.phase_now", 32'(oPHASE), 32'd0);
        iSELECT = 1'b1;
        tick(3);
        iRESET = 1'b0;
        tick(6);
        check("rmid.release_pad", 32'(oGENPAD), 32'h3F);
        check("rmid.release_phase", 32'(oPHASE), 32'd0);
        drive_sel(1'b0, 6'b111100, 3'd1, "rmid.fresh.lo");
        drive_sel(1'b1, 6'b111111, 3'd1, "rmid.fresh.hi");
        expire("rmid");

        // Release of reset with SELECT already low counts as a falling edge
        iRESET  = 1'b1;
        iSELECT = 1'b0;
        tick(3);
        iRESET = 1'b0;
        tick(4);
        check("rlow.phase", 32'(oPHASE), 32'd1);
        check("rlow.pad", 32'(oGENPAD), 32'b111100);
        iSELECT = 1'b1;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
